// File: rtl/kernel_4_mul_arbiter.sv
// Round-robin arbiter sharing one 15x16 unsigned multiplier among NREQ requesters.
// Define KERNEL_4_MUL_ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority instead.
`timescale 1ns/1ps
module kernel_4_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [15*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [30:0]          res_data,
  output logic [IDW-1:0]       res_id,
  output logic [31:0]          op_count
);

  localparam int DATA_W = 15;
  localparam int COEF_W = 16;
  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic              state_p1;
  logic [PROD_W-1:0] res_data_p1;
  logic [IDW-1:0]    res_id_p1;
  logic [31:0]       op_count_r;

  logic              accept;
  logic              gnt_found;
  logic              gnt_vld;
  logic [IDW-1:0]    gnt_idx;
  logic [DATA_W-1:0] a_p0;
  logic [COEF_W-1:0] b_p0;
  logic [PROD_W-1:0] prod_p0;

  // Full-width unsigned product; the operand widths guarantee no overflow.
  function automatic logic [PROD_W-1:0] mul_full(input logic [DATA_W-1:0] a,
                                                 input logic [COEF_W-1:0] b);
    return PROD_W'(a) * PROD_W'(b);
  endfunction

`ifdef KERNEL_4_MUL_ARB_FIXED_PRIO_EN
  // Lowest index wins; scan downward so the last hit is the smallest index.
  function automatic logic [IDW:0] pick(input logic [NREQ-1:0] v);
    logic [IDW:0] r;
    r = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) r = {1'b1, IDW'(i)};
    end
    return r;
  endfunction

  assign {gnt_found, gnt_idx} = pick(req_valid);
`else
  logic [IDW-1:0] last_grant;

  // Search upward from last_grant+1 with wrap; scanning the offsets in reverse
  // lets the nearest candidate overwrite any farther one.
  function automatic logic [IDW:0] pick(input logic [NREQ-1:0] v,
                                        input logic [IDW-1:0]  last);
    logic [IDW:0]   r;
    logic [IDW-1:0] ix;
    int             idx;
    r = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      ix  = IDW'(idx);
      if (v[ix]) r = {1'b1, ix};
    end
    return r;
  endfunction

  assign {gnt_found, gnt_idx} = pick(req_valid, last_grant);
`endif

  assign accept  = (state_p1 == ST_EMPTY) || res_ready;
  assign gnt_vld = accept && gnt_found && !ap_rst;

  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  assign a_p0    = req_a[DATA_W*gnt_idx +: DATA_W];
  assign b_p0    = req_b[COEF_W*gnt_idx +: COEF_W];
  assign prod_p0 = mul_full(a_p0, b_p0);

  // ---- stage p0 -> p1: grant cycle registers the product ----
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_p1    <= ST_EMPTY;
      res_data_p1 <= '0;
      res_id_p1   <= '0;
      op_count_r  <= '0;
    end else if (accept) begin
      if (gnt_found) begin
        state_p1    <= ST_FULL;
        res_data_p1 <= prod_p0;
        res_id_p1   <= gnt_idx;
        op_count_r  <= op_count_r + 32'd1;
      end else begin
        state_p1 <= ST_EMPTY;
      end
    end
  end

`ifndef KERNEL_4_MUL_ARB_FIXED_PRIO_EN
  always_ff @(posedge ap_clk) begin
    if (ap_rst) last_grant <= IDW'(NREQ - 1);
    else if (gnt_vld) last_grant <= gnt_idx;
  end
`endif

  assign res_valid = (state_p1 == ST_FULL);
  assign res_data  = res_data_p1;
  assign res_id    = res_id_p1;
  assign op_count  = op_count_r;

endmodule
